// File: rtl/wb_axi_drain_ctrl.sv
// Drains write-buffer head lines onto the AXI write channel as INCR bursts and slots
// uncached single-word stores in behind them once the buffer is empty.
module wb_axi_drain_ctrl #(
    parameter int DATA_W     = 32,
    parameter int LINE_BEATS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    // write buffer head
    input  logic                         wb_valid_i,
    input  logic [31:0]                  wb_addr_i,
    input  logic [DATA_W*LINE_BEATS-1:0] wb_data_i,
    output logic                         wb_pop_o,
    output logic                         wb_busy_o,
    // uncached store
    input  logic                         unc_req_i,
    input  logic [31:0]                  unc_addr_i,
    input  logic [DATA_W-1:0]            unc_data_i,
    input  logic [DATA_W/8-1:0]          unc_strb_i,
    output logic                         unc_done_o,
    output logic                         bus_err_o,
    // AXI write address
    output logic [31:0]                  awaddr_o,
    output logic [7:0]                   awlen_o,
    output logic [2:0]                   awsize_o,
    output logic [1:0]                   awburst_o,
    output logic                         awvalid_o,
    input  logic                         awready_i,
    // AXI write data
    output logic [DATA_W-1:0]            wdata_o,
    output logic [DATA_W/8-1:0]          wstrb_o,
    output logic                         wlast_o,
    output logic                         wvalid_o,
    input  logic                         wready_i,
    // AXI write response
    input  logic [1:0]                   bresp_i,
    input  logic                         bvalid_i,
    output logic                         bready_o,
    // FSM state for observation: 0 IDLE, 1 ADDR, 2 DATA, 3 RESP
    output logic [1:0]                   dbg_state
);

    // Handshakes: a transfer happens on a rising clk edge where valid and ready are both high;
    // once a valid is raised its payload is held unchanged until that edge.

    localparam int LINE_W = DATA_W * LINE_BEATS;
    localparam int BEAT_W = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
    localparam int STRB_W = DATA_W / 8;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    typedef enum logic {
        KIND_LINE = 1'b0,
        KIND_UNC  = 1'b1
    } kind_t;

    state_t              state, state_d;
    kind_t               kind, kind_d;
    logic [BEAT_W-1:0]   beat, beat_d, beat_nxt;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [STRB_W-1:0]   strb_q, strb_d;

    logic [31:0]         awaddr_d;
    logic [7:0]          awlen_d;
    logic [2:0]          awsize_d;
    logic [1:0]          awburst_d;
    logic                awvalid_d;
    logic [DATA_W-1:0]   wdata_d;
    logic [STRB_W-1:0]   wstrb_d;
    logic                wlast_d, wvalid_d, bready_d;
    logic                wb_pop_d, wb_busy_d, unc_done_d, bus_err_d;

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            kind       <= KIND_LINE;
            beat       <= '0;
            line_q     <= '0;
            strb_q     <= '0;
            awaddr_o   <= '0;
            awlen_o    <= '0;
            awsize_o   <= '0;
            awburst_o  <= '0;
            awvalid_o  <= 1'b0;
            wdata_o    <= '0;
            wstrb_o    <= '0;
            wlast_o    <= 1'b0;
            wvalid_o   <= 1'b0;
            bready_o   <= 1'b0;
            wb_pop_o   <= 1'b0;
            wb_busy_o  <= 1'b0;
            unc_done_o <= 1'b0;
            bus_err_o  <= 1'b0;
        end else begin
            state      <= state_d;
            kind       <= kind_d;
            beat       <= beat_d;
            line_q     <= line_d;
            strb_q     <= strb_d;
            awaddr_o   <= awaddr_d;
            awlen_o    <= awlen_d;
            awsize_o   <= awsize_d;
            awburst_o  <= awburst_d;
            awvalid_o  <= awvalid_d;
            wdata_o    <= wdata_d;
            wstrb_o    <= wstrb_d;
            wlast_o    <= wlast_d;
            wvalid_o   <= wvalid_d;
            bready_o   <= bready_d;
            wb_pop_o   <= wb_pop_d;
            wb_busy_o  <= wb_busy_d;
            unc_done_o <= unc_done_d;
            bus_err_o  <= bus_err_d;
        end
    end

    always_comb begin
        state_d    = state;
        kind_d     = kind;
        beat_d     = beat;
        line_d     = line_q;
        strb_d     = strb_q;
        awaddr_d   = awaddr_o;
        awlen_d    = awlen_o;
        awsize_d   = awsize_o;
        awburst_d  = awburst_o;
        awvalid_d  = awvalid_o;
        wdata_d    = wdata_o;
        wstrb_d    = wstrb_o;
        wlast_d    = wlast_o;
        wvalid_d   = wvalid_o;
        bready_d   = bready_o;
        wb_pop_d   = 1'b0;
        wb_busy_d  = wb_busy_o;
        unc_done_d = 1'b0;
        bus_err_d  = 1'b0;
        beat_nxt   = beat + BEAT_W'(1);

        case (state)
            IDLE: begin
                wb_busy_d = 1'b0;
                if (wb_valid_i) begin
                    kind_d    = KIND_LINE;
                    line_d    = wb_data_i;
                    awaddr_d  = wb_addr_i;
                    awlen_d   = 8'(LINE_BEATS - 1);
                    awsize_d  = 3'b010;
                    awburst_d = 2'b01;
                    awvalid_d = 1'b1;
                    wb_busy_d = 1'b1;
                    state_d   = ADDR;
                end else if (unc_req_i && !unc_done_o) begin
                    // The requester still shows the finished store during the done pulse.
                    kind_d    = KIND_UNC;
                    line_d    = LINE_W'(unc_data_i);
                    strb_d    = unc_strb_i;
                    awaddr_d  = unc_addr_i;
                    awlen_d   = 8'd0;
                    awsize_d  = 3'b010;
                    awburst_d = 2'b01;
                    awvalid_d = 1'b1;
                    state_d   = ADDR;
                end
            end
            ADDR: begin
                if (awvalid_o && awready_i) begin
                    awvalid_d = 1'b0;
                    beat_d    = '0;
                    wvalid_d  = 1'b1;
                    wdata_d   = line_q[DATA_W-1:0];
                    wstrb_d   = (kind == KIND_LINE) ? {STRB_W{1'b1}} : strb_q;
                    wlast_d   = (kind == KIND_UNC) || (LINE_BEATS == 1);
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (wvalid_o && wready_i) begin
                    if (wlast_o) begin
                        wvalid_d = 1'b0;
                        wlast_d  = 1'b0;
                        bready_d = 1'b1;
                        state_d  = RESP;
                    end else begin
                        beat_d  = beat_nxt;
                        wdata_d = DATA_W'(line_q >> (DATA_W * int'(beat_nxt)));
                        wlast_d = (beat_nxt == LAST_BEAT);
                    end
                end
            end
            RESP: begin
                if (bready_o && bvalid_i) begin
                    bready_d   = 1'b0;
                    wb_pop_d   = (kind == KIND_LINE);
                    unc_done_d = (kind == KIND_UNC);
                    bus_err_d  = (bresp_i != 2'b00);
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_wb_axi_drain_ctrl.sv
// Scoreboard bench for wb_axi_drain_ctrl: directed lines and uncached stores against a
// configurable AXI slave, with expected AW/W/completion records queued at issue time.
module tb_wb_axi_drain_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         wb_valid_i;
    logic [31:0]  wb_addr_i;
    logic [127:0] wb_data_i;
    logic         wb_pop_o, wb_busy_o;
    logic         unc_req_i;
    logic [31:0]  unc_addr_i, unc_data_i;
    logic [3:0]   unc_strb_i;
    logic         unc_done_o, bus_err_o;
    logic [31:0]  awaddr_o;
    logic [7:0]   awlen_o;
    logic [2:0]   awsize_o;
    logic [1:0]   awburst_o;
    logic         awvalid_o, awready_i;
    logic [31:0]  wdata_o;
    logic [3:0]   wstrb_o;
    logic         wlast_o, wvalid_o, wready_i;
    logic [1:0]   bresp_i;
    logic         bvalid_i, bready_o;
    logic [1:0]   dbg_state;

    wb_axi_drain_ctrl dut (
        .clk(clk), .rst(rst),
        .wb_valid_i(wb_valid_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
        .wb_pop_o(wb_pop_o), .wb_busy_o(wb_busy_o),
        .unc_req_i(unc_req_i), .unc_addr_i(unc_addr_i), .unc_data_i(unc_data_i),
        .unc_strb_i(unc_strb_i), .unc_done_o(unc_done_o), .bus_err_o(bus_err_o),
        .awaddr_o(awaddr_o), .awlen_o(awlen_o), .awsize_o(awsize_o), .awburst_o(awburst_o),
        .awvalid_o(awvalid_o), .awready_i(awready_i),
        .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o), .wvalid_o(wvalid_o),
        .wready_i(wready_i),
        .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;
    logic [44:0] aw_exp_q[$];   // {addr, len, size, burst}
    logic [36:0] w_exp_q[$];    // {data, strb, last}
    logic [2:0]  ev_exp_q[$];   // {pop, done, err}

    int ev_cnt = 0, w_hs_cnt = 0, pop_cnt = 0, busy_fall_cnt = 0;
    int aw_rise_cyc = -1, w_rise_cyc = -1, pop_cyc = -1, busy_rise_cyc = -1, busy_fall_cyc = -1;

    // ---------------- write buffer model ----------------
    // Head follows the pop pulse combinationally so the next entry is visible in the pop cycle.
    logic [31:0]  la[16];
    logic [127:0] ld[16];
    int n_lines = 0;
    int head = 0;
    int eff;
    always @(posedge clk) if (wb_pop_o) head <= head + 1;
    always_comb begin
        eff        = head + (wb_pop_o ? 1 : 0);
        wb_valid_i = (eff < n_lines);
        wb_addr_i  = la[eff[3:0]];
        wb_data_i  = ld[eff[3:0]];
    end

    // ---------------- AXI slave model ----------------
    int aw_delay = 0, b_delay = 0, aw_wait = 0, b_wait = 0;
    logic w_toggle = 1'b0, w_block = 1'b0;
    logic [1:0] bresp_mode = 2'b00;
    always @(posedge clk) begin
        #1;
        if (awvalid_o) begin
            awready_i = (aw_wait >= aw_delay);
            aw_wait++;
        end else begin
            awready_i = 1'b0;
            aw_wait = 0;
        end
        if (w_block) wready_i = 1'b0;
        else if (w_toggle) wready_i = ~wready_i;
        else wready_i = 1'b1;
        if (bready_o) begin
            bvalid_i = (b_wait >= b_delay);
            bresp_i  = bvalid_i ? bresp_mode : 2'b00;
            b_wait++;
        end else begin
            bvalid_i = 1'b0;
            bresp_i  = 2'b00;
            b_wait = 0;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic        prev_aw_v = 1'b0, prev_aw_hs = 1'b0, prev_w_v = 1'b0, prev_w_hs = 1'b0;
    logic        prev_pop = 1'b0, prev_busy = 1'b0;
    logic [44:0] prev_aw_pay, aw_pay, aw_exp;
    logic [36:0] prev_w_pay, w_pay, w_exp;
    logic [2:0]  ev_pay, ev_exp;

    always @(negedge clk) begin
        if (!rst) begin
            prev_aw_v = 1'b0; prev_aw_hs = 1'b0; prev_w_v = 1'b0; prev_w_hs = 1'b0;
            prev_pop = 1'b0; prev_busy = 1'b0;
        end else begin
            aw_pay = {awaddr_o, awlen_o, awsize_o, awburst_o};
            w_pay  = {wdata_o, wstrb_o, wlast_o};
            ev_pay = {wb_pop_o, unc_done_o, bus_err_o};
            if (awvalid_o && !prev_aw_v) aw_rise_cyc = cyc;
            if (wvalid_o && !prev_w_v) w_rise_cyc = cyc;
            if (awvalid_o && prev_aw_v && !prev_aw_hs) begin
                checks++;
                if (aw_pay !== prev_aw_pay) begin
                    errors++;
                    $display("FAIL aw_stable: got %h, required %h", aw_pay, prev_aw_pay);
                end
            end
            if (awvalid_o && awready_i) begin
                checks++;
                if (aw_exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL aw_unexpected: got %h, required no AW", aw_pay);
                end else begin
                    aw_exp = aw_exp_q.pop_front();
                    if (aw_pay !== aw_exp) begin
                        errors++;
                        $display("FAIL aw_payload: got %h, required %h", aw_pay, aw_exp);
                    end
                end
            end
            if (wvalid_o && prev_w_v && !prev_w_hs) begin
                checks++;
                if (w_pay !== prev_w_pay) begin
                    errors++;
                    $display("FAIL w_stable: got %h, required %h", w_pay, prev_w_pay);
                end
            end
            if (wvalid_o && wready_i) begin
                w_hs_cnt++;
                checks++;
                if (w_exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL w_unexpected: got %h, required no W", w_pay);
                end else begin
                    w_exp = w_exp_q.pop_front();
                    if (w_pay !== w_exp) begin
                        errors++;
                        $display("FAIL w_beat: got %h, required %h", w_pay, w_exp);
                    end
                end
            end
            if (ev_pay != 3'b000) begin
                ev_cnt++;
                checks++;
                if (ev_exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL completion_unexpected: got %b, required none", ev_pay);
                end else begin
                    ev_exp = ev_exp_q.pop_front();
                    if (ev_pay !== ev_exp) begin
                        errors++;
                        $display("FAIL completion: got %b, required %b", ev_pay, ev_exp);
                    end
                end
            end
            if (wb_pop_o) begin
                pop_cnt++;
                pop_cyc = cyc;
                checks++;
                if (prev_pop) begin
                    errors++;
                    $display("FAIL pop_width: got 2+ cycles, required 1");
                end
            end
            if (wb_busy_o && !prev_busy) busy_rise_cyc = cyc;
            if (!wb_busy_o && prev_busy) begin
                busy_fall_cyc = cyc;
                busy_fall_cnt++;
            end
            prev_aw_v = awvalid_o; prev_aw_hs = awvalid_o && awready_i; prev_aw_pay = aw_pay;
            prev_w_v = wvalid_o;   prev_w_hs = wvalid_o && wready_i;    prev_w_pay = w_pay;
            prev_pop = wb_pop_o;   prev_busy = wb_busy_o;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    task automatic add_line(input logic [31:0] a, input logic [127:0] d);
        la[n_lines] = a;
        ld[n_lines] = d;
        n_lines++;
    endtask

    task automatic exp_line(input logic [31:0] a, input logic [31:0] b0, input logic [31:0] b1,
                            input logic [31:0] b2, input logic [31:0] b3, input logic err);
        aw_exp_q.push_back({a, 8'd3, 3'b010, 2'b01});
        w_exp_q.push_back({b0, 4'hF, 1'b0});
        w_exp_q.push_back({b1, 4'hF, 1'b0});
        w_exp_q.push_back({b2, 4'hF, 1'b0});
        w_exp_q.push_back({b3, 4'hF, 1'b1});
        ev_exp_q.push_back({1'b1, 1'b0, err});
    endtask

    task automatic wait_ev(input int target, input int budget, input string name);
        int n = 0;
        while (ev_cnt < target && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (ev_cnt < target) begin
            errors++;
            $display("FAIL %s: completions %0d, required %0d", name, ev_cnt, target);
        end
    endtask

    function automatic logic [127:0] all_outs();
        return 128'({wb_pop_o, wb_busy_o, unc_done_o, bus_err_o, awaddr_o, awlen_o, awsize_o,
                     awburst_o, awvalid_o, wdata_o, wstrb_o, wlast_o, wvalid_o, bready_o});
    endfunction

    // ---------------- stimulus ----------------
    int c0, base, wb0, pb0, fb0;
    initial begin
        for (int i = 0; i < 16; i++) begin
            la[i] = '0;
            ld[i] = '0;
        end
        rst = 1'b0;
        unc_req_i = 1'b0; unc_addr_i = '0; unc_data_i = '0; unc_strb_i = '0;
        awready_i = 1'b0; wready_i = 1'b0; bvalid_i = 1'b0; bresp_i = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", all_outs(), '0);
        chk("reset_state", 128'(dbg_state), 128'd0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // single line, always-ready slave: latency and busy window
        exp_line(32'h1000_0010, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 1'b0);
        add_line(32'h1000_0010, 128'h44444444_33333333_22222222_11111111);
        c0 = cyc;
        wait_ev(1, 40, "line1_done");
        repeat (2) @(posedge clk);
        #1;
        chk("line1_aw_latency", 128'(aw_rise_cyc - c0), 128'd1);
        chk("line1_w_latency", 128'(w_rise_cyc - c0), 128'd2);
        chk("line1_pop_latency", 128'(pop_cyc - c0), 128'd7);
        chk("line1_busy_rise", 128'(busy_rise_cyc - c0), 128'd1);
        chk("line1_busy_fall", 128'(busy_fall_cyc - c0), 128'd8);

        // stalls on every channel
        aw_delay = 5; w_toggle = 1'b1; b_delay = 4;
        wb0 = w_hs_cnt; pb0 = pop_cnt;
        exp_line(32'h1000_0020, 32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004, 1'b0);
        add_line(32'h1000_0020, 128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001);
        wait_ev(2, 100, "stall_done");
        chk("stall_w_handshakes", 128'(w_hs_cnt - wb0), 128'd4);
        chk("stall_pops", 128'(pop_cnt - pb0), 128'd1);
        aw_delay = 0; w_toggle = 1'b0; b_delay = 0;
        repeat (2) @(posedge clk);
        #1;

        // ordering: two lines plus a pending uncached store
        fb0 = busy_fall_cnt;
        exp_line(32'h1000_0030, 32'h0303_0300, 32'h0303_0301, 32'h0303_0302, 32'h0303_0303, 1'b0);
        exp_line(32'h1000_0040, 32'h0404_0400, 32'h0404_0401, 32'h0404_0402, 32'h0404_0403, 1'b0);
        aw_exp_q.push_back({32'h2000_0004, 8'd0, 3'b010, 2'b01});
        w_exp_q.push_back({32'hCAFE_F00D, 4'b0110, 1'b1});
        ev_exp_q.push_back(3'b010);
        add_line(32'h1000_0030, 128'h03030303_03030302_03030301_03030300);
        add_line(32'h1000_0040, 128'h04040403_04040402_04040401_04040400);
        unc_addr_i = 32'h2000_0004; unc_data_i = 32'hCAFE_F00D; unc_strb_i = 4'b0110;
        unc_req_i = 1'b1;
        wait_ev(5, 120, "order_done");
        unc_req_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("order_busy_falls", 128'(busy_fall_cnt - fb0), 128'd1);

        // error response still retires the line
        bresp_mode = 2'b10;
        exp_line(32'h1000_0050, 32'h5555_0000, 32'h5555_0001, 32'h5555_0002, 32'h5555_0003, 1'b1);
        add_line(32'h1000_0050, 128'h55550003_55550002_55550001_55550000);
        wait_ev(6, 40, "error_done");
        chk("error_back_to_idle", 128'(dbg_state), 128'd0);
        bresp_mode = 2'b00;
        repeat (2) @(posedge clk);
        #1;

        // reset mid-DATA: no pop, line restarts at ADDR
        w_block = 1'b1;
        exp_line(32'h1000_0060, 32'h6666_0000, 32'h6666_0001, 32'h6666_0002, 32'h6666_0003, 1'b0);
        add_line(32'h1000_0060, 128'h66660003_66660002_66660001_66660000);
        begin
            int n = 0;
            while (!wvalid_o && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
        end
        chk("reset_reached_data", 128'(dbg_state), 128'd2);
        base = ev_cnt;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midreset_outputs", all_outs(), '0);
        chk("midreset_state", 128'(dbg_state), 128'd0);
        aw_exp_q.delete();
        w_exp_q.delete();
        ev_exp_q.delete();
        w_block = 1'b0;
        rst = 1'b1;
        c0 = cyc;
        exp_line(32'h1000_0060, 32'h6666_0000, 32'h6666_0001, 32'h6666_0002, 32'h6666_0003, 1'b0);
        wait_ev(base + 1, 40, "restart_done");
        chk("no_pop_in_reset", 128'(ev_cnt - base), 128'd1);
        chk("restart_aw_latency", 128'(aw_rise_cyc - c0), 128'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("queues_drained", 128'(aw_exp_q.size() + w_exp_q.size() + ev_exp_q.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: got timeout, required completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
